// File: rtl/mmcm_drp_sequencer.sv
// rtl/mmcm_drp_sequencer.sv - MMCM run-time reconfiguration through DRP with
// masked read-modify-write table, reset hold and lock-wait with timeouts.
module mmcm_drp_sequencer #(
  parameter int TBL_DEPTH    = 8,
  parameter int RST_SETTLE   = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tbl_we,
  input  logic [2:0]  tbl_idx,
  input  logic [6:0]  tbl_addr,
  input  logic [15:0] tbl_mask,
  input  logic [15:0] tbl_data,
  input  logic [3:0]  num_entries,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        locked_sync,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam int IDX_W = $clog2(TBL_DEPTH);
  localparam int RS_W  = $clog2(RST_SETTLE + 1);
  localparam int DT_W  = $clog2(DRDY_TIMEOUT + 1);
  localparam int LT_W  = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, RST_HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, LOCK_WAIT, FINISH
  } state_t;

  state_t            state;
  logic [6:0]        addr_mem [TBL_DEPTH];
  logic [15:0]       mask_mem [TBL_DEPTH];
  logic [15:0]       data_mem [TBL_DEPTH];
  logic [IDX_W:0]    idx;
  logic [IDX_W:0]    n_q;
  logic [RS_W-1:0]   rs_cnt;
  logic [DT_W-1:0]   dt_cnt;
  logic [LT_W-1:0]   lt_cnt;
  logic              seen_low;
  logic              lock_meta;

  logic [IDX_W:0]    idx_nxt;
  logic [IDX_W:0]    n_clamp;
  logic [6:0]        cur_addr;
  logic [15:0]       cur_mask;
  logic [15:0]       cur_data;

  assign idx_nxt  = idx + (IDX_W+1)'(1);
  assign n_clamp  = (int'(num_entries) > TBL_DEPTH) ? (IDX_W+1)'(TBL_DEPTH)
                                                    : (IDX_W+1)'(num_entries);
  assign cur_addr = addr_mem[idx[IDX_W-1:0]];
  assign cur_mask = mask_mem[idx[IDX_W-1:0]];
  assign cur_data = data_mem[idx[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (tbl_we && state == IDLE) begin
      addr_mem[tbl_idx] <= tbl_addr;
      mask_mem[tbl_idx] <= tbl_mask;
      data_mem[tbl_idx] <= tbl_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta   <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      lock_meta   <= mmcm_locked;
      locked_sync <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 2'd0;
      drp_daddr <= 7'd0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_di    <= 16'd0;
      mmcm_rst  <= 1'b0;
      idx       <= '0;
      n_q       <= '0;
      rs_cnt    <= '0;
      dt_cnt    <= '0;
      lt_cnt    <= '0;
      seen_low  <= 1'b0;
    end else begin
      done    <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= RST_HOLD;
          busy     <= 1'b1;
          mmcm_rst <= 1'b1;
          err      <= 2'd0;
          rs_cnt   <= '0;
          idx      <= '0;
          n_q      <= n_clamp;
        end
        RST_HOLD: begin
          if (rs_cnt == RS_W'(RST_SETTLE - 1)) begin
            if (n_q == '0) begin
              state    <= RELEASE;
              mmcm_rst <= 1'b0;
              lt_cnt   <= '0;
              seen_low <= 1'b0;
            end else begin
              state     <= RD_REQ;
              drp_den   <= 1'b1;
              drp_daddr <= cur_addr;
            end
          end else begin
            rs_cnt <= rs_cnt + RS_W'(1);
          end
        end
        RD_REQ: begin
          state  <= RD_WAIT;
          dt_cnt <= DT_W'(1);
        end
        RD_WAIT: begin
          if (drp_drdy) begin
            state   <= WR_REQ;
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            drp_di  <= (drp_do & cur_mask) | (cur_data & ~cur_mask);
          end else if (dt_cnt == DT_W'(DRDY_TIMEOUT - 1)) begin
            err      <= 2'd1;
            state    <= RELEASE;
            mmcm_rst <= 1'b0;
            lt_cnt   <= '0;
            seen_low <= 1'b0;
          end else begin
            dt_cnt <= dt_cnt + DT_W'(1);
          end
        end
        WR_REQ: begin
          state  <= WR_WAIT;
          dt_cnt <= DT_W'(1);
        end
        WR_WAIT: begin
          if (drp_drdy) begin
            if (idx_nxt == n_q) begin
              state    <= RELEASE;
              mmcm_rst <= 1'b0;
              lt_cnt   <= '0;
              seen_low <= 1'b0;
            end else begin
              idx       <= idx_nxt;
              state     <= RD_REQ;
              drp_den   <= 1'b1;
              drp_daddr <= addr_mem[idx_nxt[IDX_W-1:0]];
            end
          end else if (dt_cnt == DT_W'(DRDY_TIMEOUT - 1)) begin
            err      <= 2'd1;
            state    <= RELEASE;
            mmcm_rst <= 1'b0;
            lt_cnt   <= '0;
            seen_low <= 1'b0;
          end else begin
            dt_cnt <= dt_cnt + DT_W'(1);
          end
        end
        RELEASE: begin
          lt_cnt <= lt_cnt + LT_W'(1);
          if (err != 2'd0) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= LOCK_WAIT;
          end
        end
        // A high lock only counts once a low has been seen after release,
        // so the synchronizer's stale pre-reset value cannot end the wait.
        LOCK_WAIT: begin
          lt_cnt <= lt_cnt + LT_W'(1);
          if (!locked_sync) seen_low <= 1'b1;
          if (locked_sync && seen_low) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (lt_cnt == LT_W'(LOCK_TIMEOUT - 1)) begin
            err   <= 2'd2;
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// tb/tb_mmcm_drp_sequencer.sv - randomized self-checking bench with DRP
// device, MMCM lock model and transaction-level reference model.
module tb_mmcm_drp_sequencer;
  localparam int LT = 200;
  localparam int DT = 64;
  localparam int RS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tbl_we;
  logic [2:0]  tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_mask;
  logic [15:0] tbl_data;
  logic [3:0]  num_entries;
  logic        start;
  logic        busy, done, locked_sync, drp_den, drp_dwe, mmcm_rst;
  logic [1:0]  err;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        mmcm_locked;

  mmcm_drp_sequencer #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .resetn(resetn), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data),
    .num_entries(num_entries), .start(start), .busy(busy), .done(done),
    .err(err), .locked_sync(locked_sync), .drp_daddr(drp_daddr),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do),
    .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] dev_regs [128];
  logic [6:0]  t_addr [8];
  logic [15:0] t_mask [8];
  logic [15:0] t_data [8];

  bit          pending = 0, hang = 0;
  int          cd = 0, resp_lat = 2, rd_count = 0, hang_idx = -1;
  int          lock_delay = 3, rel_cnt = 0, overlap = 0;
  logic [6:0]  p_addr;
  logic        p_we;
  logic [15:0] p_di;
  int          obs_addr[$], obs_we[$], obs_di[$], obs_cyc[$];

  logic        prev_rst = 0;
  logic [1:0]  prev_err = 0;
  int          rst_rise_cyc = -1, rst_fall_cyc = -1, err_chg_cyc = -1;
  int          done_cnt = 0, done_cyc = -1;
  logic        done_busy;
  logic [1:0]  done_err;

  // Monitor, DRP device and MMCM lock behaviour, all evaluated mid-cycle.
  initial begin : models
    drp_drdy    = 1'b0;
    drp_do      = 16'h0;
    mmcm_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (mmcm_rst && !prev_rst) rst_rise_cyc = cyc;
      if (!mmcm_rst && prev_rst) rst_fall_cyc = cyc;
      if (err != prev_err && err != 2'd0) err_chg_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
        done_err  = err;
      end
      prev_rst = mmcm_rst;
      prev_err = err;

      drp_drdy = 1'b0;
      if (drp_den) begin
        if (pending) overlap++;
        obs_addr.push_back(int'(drp_daddr));
        obs_we.push_back(int'(drp_dwe));
        obs_di.push_back(int'(drp_di));
        obs_cyc.push_back(cyc);
        pending = 1;
        cd      = resp_lat;
        p_addr  = drp_daddr;
        p_we    = drp_dwe;
        p_di    = drp_di;
        if (!drp_dwe) begin
          if (rd_count == hang_idx) hang = 1;
          rd_count++;
        end
      end else if (pending && !hang) begin
        cd--;
        if (cd <= 0) begin
          drp_drdy = 1'b1;
          if (p_we) dev_regs[p_addr] = p_di;
          else drp_do = dev_regs[p_addr];
          pending = 0;
        end
      end

      if (mmcm_rst) begin
        mmcm_locked = 1'b0;
        rel_cnt     = 0;
      end else if (!mmcm_locked && lock_delay >= 0) begin
        rel_cnt++;
        if (rel_cnt >= lock_delay) mmcm_locked = 1'b1;
      end
    end
  end

  task automatic load_entry(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_idx  = 3'(i);
    tbl_addr = a;
    tbl_mask = m;
    tbl_data = d;
    t_addr[i] = a;
    t_mask[i] = m;
    t_data[i] = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int n, input int hang_rd, input int ldly,
                         input int lat, input bit poke);
    logic [15:0] snap [128];
    int e_addr[$], e_we[$], e_di[$];
    int k, exp_err, done_before, c, a, nv;
    snap = dev_regs;
    k = (n > 8) ? 8 : n;
    for (int i = 0; i < k; i++) begin
      a = int'(t_addr[i]);
      e_addr.push_back(a); e_we.push_back(0); e_di.push_back(0);
      if (i == hang_rd) break;
      nv = int'((snap[a] & t_mask[i]) | (t_data[i] & ~t_mask[i]));
      e_addr.push_back(a); e_we.push_back(1); e_di.push_back(nv);
      snap[a] = 16'(nv);
    end
    exp_err = (hang_rd >= 0 && hang_rd < k) ? 1 : (ldly < 0) ? 2 : 0;

    pending = 0; hang = 0; rd_count = 0; overlap = 0;
    hang_idx = hang_rd; resp_lat = lat; lock_delay = ldly;
    obs_addr.delete(); obs_we.delete(); obs_di.delete(); obs_cyc.delete();
    done_before = done_cnt;

    @(negedge clk);
    num_entries = 4'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (done_cnt == done_before && c < 3000) begin
      @(negedge clk); #1;
      c++;
      if (poke && c == 4) begin
        tbl_we = 1'b1; tbl_idx = 3'd0; tbl_addr = 7'h7f;
        tbl_mask = 16'h0; tbl_data = 16'hdead; start = 1'b1;
      end
      if (poke && c == 8) begin
        tbl_we = 1'b0; start = 1'b0;
      end
    end
    tbl_we = 1'b0;
    start  = 1'b0;

    check({tag, "/done"}, done_cnt == done_before + 1, 1);
    check({tag, "/err"}, done_err, exp_err);
    check({tag, "/busy_at_done"}, done_busy, 0);
    check({tag, "/rst_low"}, mmcm_rst, 0);
    check({tag, "/overlap"}, overlap, 0);
    check({tag, "/ntx"}, obs_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < obs_addr.size(); i++) begin
      check($sformatf("%s/tx%0d_addr", tag, i), obs_addr[i], e_addr[i]);
      check($sformatf("%s/tx%0d_we", tag, i), obs_we[i], e_we[i]);
      if (e_we[i] == 1) check($sformatf("%s/tx%0d_di", tag, i), obs_di[i], e_di[i]);
    end
    if (k > 0 && obs_cyc.size() > 0)
      check({tag, "/rst_hold"}, (obs_cyc[0] - rst_rise_cyc) >= RS, 1);
    if (k == 0)
      check({tag, "/rst_width"}, rst_fall_cyc - rst_rise_cyc, RS);
    if (exp_err == 1 && obs_cyc.size() > 2 * hang_rd)
      check({tag, "/drdy_tmo"}, err_chg_cyc - obs_cyc[2 * hang_rd], DT);
    if (exp_err == 2)
      check({tag, "/lock_tmo"}, err_chg_cyc - rst_fall_cyc, LT);
    if (exp_err == 0)
      check({tag, "/lock_lat"}, (done_cyc - rst_fall_cyc >= ldly) && (done_cyc - rst_fall_cyc <= ldly + 6), 1);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "/err_hold"}, err, exp_err);
    check({tag, "/idle"}, busy, 0);
  endtask

  initial begin : stim
    int dc;
    resetn = 1'b0; start = 1'b0; tbl_we = 1'b0; tbl_idx = 3'd0;
    tbl_addr = 7'd0; tbl_mask = 16'd0; tbl_data = 16'd0; num_entries = 4'd0;
    for (int i = 0; i < 128; i++) dev_regs[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    #1;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/err", err, 0);
    check("rst/den", drp_den, 0);
    check("rst/dwe", drp_dwe, 0);
    check("rst/daddr", drp_daddr, 0);
    check("rst/di", drp_di, 0);
    check("rst/mmcm_rst", mmcm_rst, 0);
    check("rst/locked_sync", locked_sync, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    load_entry(0, 7'h08, 16'h1000, 16'h0145);
    dev_regs[8] = 16'hF3C3;
    run_seq("single", 1, -1, 100, 3, 0);

    load_entry(0, 7'h10, 16'($urandom), 16'($urandom));
    load_entry(1, 7'h20, 16'($urandom), 16'($urandom));
    load_entry(2, 7'h30, 16'($urandom), 16'($urandom));
    run_seq("three", 3, -1, 20, $urandom_range(1, 5), 0);
    run_seq("drdy_tmo", 3, 1, 20, 2, 0);
    run_seq("lock_tmo", 2, -1, -1, 2, 0);
    run_seq("pulse_only", 0, -1, 10, 2, 0);

    for (int i = 0; i < 8; i++) load_entry(i, 7'($urandom), 16'($urandom), 16'($urandom));
    run_seq("clamp12", 12, -1, 10, 1, 0);
    run_seq("busy_poke", 4, -1, 15, 4, 1);
    run_seq("after_poke", 2, -1, 10, 2, 0);

    // Reset while a write is outstanding.
    pending = 0; hang = 0; rd_count = 0; hang_idx = -1; resp_lat = 15; lock_delay = 5;
    obs_we.delete(); obs_addr.delete(); obs_di.delete(); obs_cyc.delete();
    @(negedge clk);
    num_entries = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    while (!(obs_we.size() > 0 && obs_we[obs_we.size() - 1] == 1) && dc < 500) begin
      @(negedge clk);
      dc++;
    end
    check("midrst/reached_wr", dc < 500, 1);
    repeat (3) @(negedge clk);
    #2;
    dc = done_cnt;
    resetn = 1'b0;
    #1;
    check("midrst/busy", busy, 0);
    check("midrst/mmcm_rst", mmcm_rst, 0);
    check("midrst/den", drp_den, 0);
    check("midrst/dwe", drp_dwe, 0);
    check("midrst/err", err, 0);
    check("midrst/daddr", drp_daddr, 0);
    check("midrst/di", drp_di, 0);
    repeat (2) @(negedge clk);
    pending = 0;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("midrst/no_done", done_cnt, dc);
    check("midrst/idle", busy, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) load_entry(i, 7'($urandom), 16'($urandom), 16'($urandom));
      run_seq($sformatf("rand%0d", it), $urandom_range(0, 12), -1,
              $urandom_range(3, 60), $urandom_range(1, 6), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Reconfigures the camera clocking MMCM (clk_fast / clk_slow generator) at run time through its DRP port.
- Holds the MMCM in reset and applies a small host-loaded table of masked read-modify-write register updates.
- Releases the reset, waits for relock with a timeout, then reports status.
- Sits between the control register block (AXI-lite side) and the MMCME2_ADV DRP, RST and LOCKED pins. Runs on the DRP clock.

Parameters:
- TBL_DEPTH, 8, number of table entries (index width = clog2).
- RST_SETTLE, 4, cycles mmcm_rst is held before the first DRP access.
- DRDY_TIMEOUT, 64, max cycles from drp_den to drp_drdy.
- LOCK_TIMEOUT, 65535, max cycles from mmcm_rst release to synchronized lock.

Ports:
- clk  in  1  DRP/control clock; also drives drp_dclk externally.
- resetn  in  1  asynchronous active-low reset.
- tbl_we  in  1  write strobe for the table entry at tbl_idx.
- tbl_idx  in  3  table entry index.
- tbl_addr  in  7  DRP address for the entry.
- tbl_mask  in  16  1 = keep the existing bit, 0 = replace it.
- tbl_data  in  16  replacement bits.
- num_entries  in  4  entries to apply; values above TBL_DEPTH are clamped to TBL_DEPTH.
- start  in  1  begin a reconfiguration sequence (level, sampled in IDLE).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at sequence end.
- err  out  2  0 = ok, 1 = DRDY timeout, 2 = lock timeout. Valid from done until the next start.
- locked_sync  out  1  2-flop synchronized mmcm_locked.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, single-cycle pulse.
- drp_dwe  out  1  DRP write enable, only high together with drp_den.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP ready.
- mmcm_rst  out  1  MMCM RST, active-high.
- mmcm_locked  in  1  MMCM LOCKED (asynchronous).

Behaviour:
- Reset (async assert, sync release): all outputs 0, including mmcm_rst (MMCM free-runs), err = 0, FSM in IDLE. Table contents are not reset.
- Reset mid-sequence: abort immediately and release mmcm_rst. The MMCM relocks with whatever registers were already written; no done pulse.
- Table: written only when tbl_we is high and the FSM is in IDLE. Writes while busy are ignored.
- FSM states: IDLE, RST_HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, LOCK_WAIT, FINISH.
- IDLE: start = 1 → RST_HOLD. Next cycle mmcm_rst = 1 and busy = 1; err clears to 0. start while busy is ignored.
- RST_HOLD: counts RST_SETTLE cycles. Then go to RD_REQ with entry index 0, or to RELEASE if the clamped num_entries = 0 (a pure reset pulse).
- RD_REQ: one cycle with drp_den = 1, drp_dwe = 0, drp_daddr = tbl_addr[i] → RD_WAIT.
- RD_WAIT: on drp_drdy, capture new = (drp_do & mask[i]) | (data[i] & ~mask[i]) → WR_REQ.
- WR_REQ: one cycle with drp_den = 1, drp_dwe = 1, same address, drp_di = new → WR_WAIT.
- WR_WAIT: on drp_drdy, i++. If i = num_entries → RELEASE, else → RD_REQ.
- DRDY timeout: in RD_WAIT or WR_WAIT, if drp_drdy is absent for DRDY_TIMEOUT cycles after den, set err = 1 and go to RELEASE. No further DRP accesses; lock wait is skipped (go straight to FINISH once mmcm_rst = 0).
- drdy outside a WAIT state is ignored.
- RELEASE: mmcm_rst = 0 next cycle, lock counter cleared → LOCK_WAIT (or FINISH if err ≠ 0).
- LOCK_WAIT: locked_sync = 1 → FINISH. If counter reaches LOCK_TIMEOUT, set err = 2 → FINISH.
- Lock sampling: locked_sync must be observed low-then-high within LOCK_WAIT. A stale high seen in the first 2 cycles after release (synchronizer latency) is ignored.
- FINISH: done = 1 for one cycle, busy = 0 on the same edge → IDLE.
- drp_daddr and drp_di hold their last values between accesses. den is never asserted again until the outstanding drdy arrives or times out.

Test Plan:
- Table entry 0 = {0x08, mask 0x1000, data 0x0145}, num_entries = 1, start. Model returns drp_do = 0xF3C3 after 3 cycles → exactly one read then one write to 0x08 with di = 0x1145. mmcm_rst is high ≥ 4 cycles before the read. locked raised 100 cycles after release → done with err = 0, busy low.
- num_entries = 3 with distinct addresses → six DRP transactions in order R0 W0 R1 W1 R2 W2, den always single-cycle, no overlap.
- DRP model never asserts drdy on the 2nd read → err = 1 at 64 cycles after den, mmcm_rst released, done pulses, no write issued.
- locked held low after release → err = 2 exactly LOCK_TIMEOUT cycles after release (parameter overridden to 200 for sim), done pulses.
- num_entries = 0 → rst pulse of 4 cycles, no DRP activity, done after lock. num_entries = 12 → exactly 8 entries applied.
- resetn pulsed low during WR_WAIT → all outputs 0 immediately. start and tbl_we asserted while busy → no effect on table contents or on the sequence.
